// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit: a PC-indexed table of 2-bit saturating
// counters for fetch, EX-stage condition evaluation, and mispredict statistics.
module branch_predict_unit #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter logic [1:0]  INIT_STATE  = 2'b01,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  lookup_pc,
   output logic             lookup_taken,
   input  logic             res_valid,
   input  logic [XLEN-1:0]  res_pc,
   input  logic [XLEN-1:0]  ru_rs1,
   input  logic [XLEN-1:0]  ru_rs2,
   input  logic [4:0]       BrOp,
   input  logic             res_pred_taken,
   input  logic             clear_stats,
   output logic             out_valid,
   output logic             NextPCsrc,
   output logic             mispredict,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [IDX_W-1:0] lookup_idx;
   logic [IDX_W-1:0] res_idx;
   logic             is_cond;
   logic             is_jump;
   logic             taken_d;
   logic             mispred_d;
   logic             train_en;
   logic [1:0]       ctr_cur;
   logic [1:0]       ctr_d;
   logic             out_valid_q;
   logic             next_pc_src_q;
   logic             mispred_q;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispred_cnt_q;
   logic             pc_unused;

   assign lookup_idx = lookup_pc[IDX_W+1:2];
   assign res_idx    = res_pc[IDX_W+1:2];
   assign pc_unused  = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                         res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

   // Read is taken from the registered table, so a same-cycle write is not visible.
   assign lookup_taken = bht_q[lookup_idx][1];

   assign is_cond = (BrOp[4:3] == 2'b01);
   assign is_jump = BrOp[4];

   // Condition evaluation and mispredict decision for the resolving instruction.
   always_comb begin
      taken_d   = 1'b0;
      mispred_d = 1'b0;
      if (is_jump) begin
         taken_d = 1'b1;
      end else if (is_cond) begin
         case (BrOp[2:0])
            3'b000:  taken_d = (ru_rs1 == ru_rs2);
            3'b001:  taken_d = (ru_rs1 != ru_rs2);
            3'b100:  taken_d = ($signed(ru_rs1) <  $signed(ru_rs2));
            3'b101:  taken_d = ($signed(ru_rs1) >= $signed(ru_rs2));
            3'b110:  taken_d = (ru_rs1 <  ru_rs2);
            3'b111:  taken_d = (ru_rs1 >= ru_rs2);
            default: taken_d = 1'b0;
         endcase
      end
      if (res_valid && (is_cond || is_jump)) begin
         mispred_d = taken_d ^ res_pred_taken;
      end
   end

   assign train_en = res_valid && is_cond;
   assign ctr_cur  = bht_q[res_idx];

   always_comb begin
      ctr_d = ctr_cur;
      if (taken_d) begin
         if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'(1);
      end else begin
         if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= INIT_STATE;
      end else if (train_en) begin
         bht_q[res_idx] <= ctr_d;
      end
   end

   // One-cycle result registers; an idle cycle clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         next_pc_src_q <= 1'b0;
         mispred_q     <= 1'b0;
      end else begin
         out_valid_q   <= res_valid;
         next_pc_src_q <= res_valid & taken_d;
         mispred_q     <= mispred_d;
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (clear_stats) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (train_en && !(&branch_cnt_q))  branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
         if (mispred_d && !(&mispred_cnt_q)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign out_valid   = out_valid_q;
   assign NextPCsrc   = next_pc_src_q;
   assign mispredict  = mispred_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
